// File: rtl/ship_pkg.sv
// Shared types and default field constants for the player-ship controller,
// renderer and collision logic.
package ship_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dir_t;

  localparam int DEF_LEFT_LIMIT  = 0;
  localparam int DEF_RIGHT_LIMIT = 19;
  localparam int DEF_RESET_X     = 5;

endpackage

// File: rtl/ship_step.sv
// Combinational next-column calculator; clamps at the field edges, or wraps
// around them when SHIP_WRAP_EN is defined.
module ship_step
  import ship_pkg::*;
#(
  parameter int X_W         = 5,
  parameter int LEFT_LIMIT  = DEF_LEFT_LIMIT,
  parameter int RIGHT_LIMIT = DEF_RIGHT_LIMIT,
  parameter int STEP        = 1
) (
  input  logic [X_W-1:0] x,
  input  dir_t           dir,
  output logic [X_W-1:0] next_x
);

  localparam logic [X_W:0] STEP_W      = (X_W+1)'(STEP);
  localparam logic [X_W:0] RIGHT_W     = (X_W+1)'(RIGHT_LIMIT);
  localparam logic [X_W:0] LEFT_STEP_W = (X_W+1)'(LEFT_LIMIT + STEP);
`ifdef SHIP_WRAP_EN
  localparam logic [X_W:0] SPAN_W      = (X_W+1)'(RIGHT_LIMIT - LEFT_LIMIT + 1);
`else
  localparam logic [X_W-1:0] LEFT_X    = X_W'(LEFT_LIMIT);
  localparam logic [X_W-1:0] RIGHT_X   = X_W'(RIGHT_LIMIT);
`endif

  // One spare bit so x+STEP and x+SPAN cannot overflow before the compare.
  logic [X_W:0] x_w;
  logic [X_W:0] inc_w;

  always_comb begin
    x_w    = {1'b0, x};
    inc_w  = x_w + STEP_W;
    next_x = x;
    case (dir)
      LEFT: begin
        if (x_w >= LEFT_STEP_W) next_x = X_W'(x_w - STEP_W);
`ifdef SHIP_WRAP_EN
        else                    next_x = X_W'(x_w + SPAN_W - STEP_W);
`else
        else                    next_x = LEFT_X;
`endif
      end
      RIGHT: begin
        if (inc_w <= RIGHT_W)   next_x = X_W'(inc_w);
`ifdef SHIP_WRAP_EN
        else                    next_x = X_W'(inc_w - SPAN_W);
`else
        else                    next_x = RIGHT_X;
`endif
      end
      default: next_x = x;
    endcase
  end

endmodule

// File: rtl/ship_ctrl.sv
// Player-ship column controller with initial-delay / auto-repeat hold behaviour.
// Optional edge wrap-around is enabled by defining SHIP_WRAP_EN.
//
// state  | meaning
// IDLE   | no button held; any press moves at once
// DELAY  | first move done, counting INIT_DELAY_TICKS frame ticks
// REPEAT | auto-repeating, one move every REPEAT_TICKS frame ticks
module ship_ctrl
  import ship_pkg::*;
#(
  parameter int X_W              = 5,
  parameter int LEFT_LIMIT       = DEF_LEFT_LIMIT,
  parameter int RIGHT_LIMIT      = DEF_RIGHT_LIMIT,
  parameter int RESET_X          = DEF_RESET_X,
  parameter int STEP             = 1,
  parameter int INIT_DELAY_TICKS = 8,
  parameter int REPEAT_TICKS     = 2
) (
  input  logic           i_clk_36MHz,
  input  logic           i_reset,
  input  logic           i_frame_tick,
  input  logic           i_left_debounced,
  input  logic           i_right_debounced,
  output logic [X_W-1:0] o_ship_x,
  output logic           o_at_left,
  output logic           o_at_right,
  output logic           o_move_pulse
);

  localparam int CNT_MAX = (INIT_DELAY_TICKS > REPEAT_TICKS) ? INIT_DELAY_TICKS : REPEAT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INIT_CNT  = CNT_W'(INIT_DELAY_TICKS);
  localparam logic [CNT_W-1:0] REP_CNT   = CNT_W'(REPEAT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [X_W-1:0]   RESET_XV  = X_W'(RESET_X);
  localparam logic [X_W-1:0]   LEFT_XV   = X_W'(LEFT_LIMIT);
  localparam logic [X_W-1:0]   RIGHT_XV  = X_W'(RIGHT_LIMIT);

  state_t           state;
  dir_t             last_dir;
  dir_t             dir;
  logic [CNT_W-1:0] cnt;
  logic [X_W-1:0]   next_x;
  logic             new_press;
  logic             take_move;

  always_comb begin
    dir = NONE;
    if (i_left_debounced && !i_right_debounced)      dir = LEFT;
    else if (i_right_debounced && !i_left_debounced) dir = RIGHT;
  end

  // A press out of IDLE or a direction change restarts the hold and beats a coincident tick.
  assign new_press = (dir != NONE) && ((state == IDLE) || (dir != last_dir));
  assign take_move = new_press ||
                     ((dir != NONE) && (state != IDLE) && i_frame_tick && (cnt == CNT_ONE));

  ship_step #(
    .X_W        (X_W),
    .LEFT_LIMIT (LEFT_LIMIT),
    .RIGHT_LIMIT(RIGHT_LIMIT),
    .STEP       (STEP)
  ) u_step (
    .x     (o_ship_x),
    .dir   (dir),
    .next_x(next_x)
  );

  always_ff @(posedge i_clk_36MHz) begin
    if (!i_reset) begin
      state        <= IDLE;
      last_dir     <= NONE;
      cnt          <= '0;
      o_ship_x     <= RESET_XV;
      o_move_pulse <= 1'b0;
      o_at_left    <= (RESET_XV == LEFT_XV);
      o_at_right   <= (RESET_XV == RIGHT_XV);
    end else begin
      o_move_pulse <= 1'b0;
      if (dir == NONE) begin
        state <= IDLE;
      end else if (new_press) begin
        state    <= DELAY;
        last_dir <= dir;
        cnt      <= INIT_CNT;
      end else if (i_frame_tick) begin
        if (cnt == CNT_ONE) begin
          state <= REPEAT;
          cnt   <= REP_CNT;
        end else begin
          cnt <= cnt - CNT_ONE;
        end
      end

      if (take_move) begin
        o_ship_x     <= next_x;
        o_move_pulse <= (next_x != o_ship_x);
        o_at_left    <= (next_x == LEFT_XV);
        o_at_right   <= (next_x == RIGHT_XV);
      end
    end
  end

endmodule

// File: tb/tb_ship_ctrl.sv
// Scoreboard bench for ship_ctrl: directed hold sequences plus random buttons,
// ticks and resets, checked against a hold-time reference model.
module tb_ship_ctrl;
  localparam int X_W  = 5;
  localparam int LL   = 0;
  localparam int RL   = 19;
  localparam int RX   = 5;
  localparam int STEP = 1;
  localparam int INIT = 8;
  localparam int REP  = 2;
  localparam int SPAN = RL - LL + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tick;
  logic           btn_l;
  logic           btn_r;
  logic [X_W-1:0] ship_x;
  logic           at_l;
  logic           at_r;
  logic           pulse;

  always #14 clk = ~clk;

  ship_ctrl #(
    .X_W(X_W), .LEFT_LIMIT(LL), .RIGHT_LIMIT(RL), .RESET_X(RX),
    .STEP(STEP), .INIT_DELAY_TICKS(INIT), .REPEAT_TICKS(REP)
  ) dut (
    .i_clk_36MHz      (clk),
    .i_reset          (rst_n),
    .i_frame_tick     (tick),
    .i_left_debounced (btn_l),
    .i_right_debounced(btn_r),
    .o_ship_x         (ship_x),
    .o_at_left        (at_l),
    .o_at_right       (at_r),
    .o_move_pulse     (pulse)
  );

  typedef struct {
    int x;
    bit p;
    bit al;
    bit ar;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: position, held direction (-1/0/+1) and ticks since the press.
  int   m_x    = RX;
  int   m_hold = 0;
  int   m_k    = 0;

  function automatic int move_x(int x, int d);
    int n;
    n = x + d * STEP;
`ifdef SHIP_WRAP_EN
    if (n < LL) n = n + SPAN;
    if (n > RL) n = n - SPAN;
`else
    if (n < LL) n = LL;
    if (n > RL) n = RL;
`endif
    return n;
  endfunction

  task automatic model_cycle(bit rv, bit tv, bit lv, bit rtv);
    exp_t e;
    int   d;
    bit   mv;
    int   nx;
    e.p = 1'b0;
    if (!rv) begin
      m_x    = RX;
      m_hold = 0;
      m_k    = 0;
    end else begin
      d  = (lv && !rtv) ? -1 : ((rtv && !lv) ? 1 : 0);
      mv = 1'b0;
      if (d == 0) begin
        m_hold = 0;
      end else if (d != m_hold) begin
        m_hold = d;
        m_k    = 0;
        mv     = 1'b1;
      end else if (tv) begin
        m_k++;
        if (m_k == INIT || (m_k > INIT && (m_k - INIT) % REP == 0)) mv = 1'b1;
      end
      if (mv) begin
        nx  = move_x(m_x, d);
        e.p = (nx != m_x);
        m_x = nx;
      end
    end
    e.x   = m_x;
    e.al  = (m_x == LL);
    e.ar  = (m_x == RL);
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic step_cycle(bit rv, bit tv, bit lv, bit rtv);
    @(negedge clk);
    rst_n = rv;
    tick  = tv;
    btn_l = lv;
    btn_r = rtv;
    cyc++;
    model_cycle(rv, tv, lv, rtv);
  endtask

  task automatic hold(int n, bit lv, bit rtv, int per);
    for (int i = 0; i < n; i++) step_cycle(1'b1, (i % per) == per - 1, lv, rtv);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ship_x !== X_W'(e.x) || pulse !== e.p || at_l !== e.al || at_r !== e.ar) begin
          errors++;
          $display("FAIL outputs cycle %0d: got x=%0d pulse=%b at_l=%b at_r=%b, expected x=%0d pulse=%b at_l=%b at_r=%b",
                   e.cyc, ship_x, pulse, at_l, at_r, e.x, e.p, e.al, e.ar);
        end
      end
    end
  end

  initial begin : driver
    bit cur_l;
    bit cur_r;
    rst_n = 1'b0;
    tick  = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;

    for (int i = 0; i < 3; i++) step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    hold(2, 1'b0, 1'b0, 3);
    hold(1, 1'b0, 1'b1, 3);          // single-cycle right press
    hold(4, 1'b0, 1'b0, 3);
    hold(60, 1'b0, 1'b1, 3);         // right held: delay then repeats
    hold(3, 1'b0, 1'b0, 3);
    hold(60, 1'b1, 1'b1, 3);         // both held: no movement
    hold(200, 1'b1, 1'b0, 2);        // run into the left edge and keep holding
    hold(200, 1'b0, 1'b1, 2);        // run into the right edge
    hold(2, 1'b0, 1'b0, 2);
    hold(9, 1'b0, 1'b1, 3);          // right for 3 ticks, then direction change
    hold(30, 1'b1, 1'b0, 3);
    hold(40, 1'b0, 1'b1, 2);         // into REPEAT, then reset mid-hold
    step_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    hold(12, 1'b0, 1'b1, 2);
    hold(3, 1'b0, 1'b0, 2);

    cur_l = 1'b0;
    cur_r = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cur_l = 1'($urandom_range(0, 1));
        cur_r = 1'($urandom_range(0, 1));
      end
      step_cycle($urandom_range(0, 399) != 0, $urandom_range(0, 3) == 0, cur_l, cur_r);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
